// File: rtl/scv_pkg.sv
// Shared types and constants for the SCV VRAM subsystem.
package scv_pkg;

    localparam logic [15:0] VRAM_BASE = 16'h3000;
    localparam int          VRAM_AW   = 10;

    typedef enum logic [1:0] {
        G_IDLE,
        G_CPU_RD,
        G_CPU_WR,
        G_VID
    } grant_t;

endpackage

// File: rtl/scv_vram_sp.sv
// Single-port synchronous RAM: write on posedge, registered read, one access per CLK.
module scv_vram_sp #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // NOTE: the array and read register have no reset; contents must survive RESET and RAM macros cannot be cleared.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scv_vram_arb.sv
// SCV VRAM arbiter: CPU accesses in fixed CP1/CP2 slots, video reads in every free CLK.
module scv_vram_arb
    import scv_pkg::*;
#(
    parameter int AW     = VRAM_AW,
    parameter int DW     = 8,
    parameter int STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CP1_NEGEDGE,
    input  logic              CP2_NEGEDGE,
    input  logic              CPU_NCS,
    input  logic              CPU_RDB,
    input  logic              CPU_WRB,
    input  logic [AW-1:0]     CPU_A,
    input  logic [DW-1:0]     CPU_DI,
    output logic [DW-1:0]     CPU_DO,
    input  logic              VID_REQ,
    input  logic [AW-1:0]     VID_A,
    output logic              VID_ACK,
    output logic [DW-1:0]     VID_DO,
    output logic              VID_DV,
    output logic [STAT_W-1:0] VID_STALLS,
    output logic              CPU_ERR
);

    grant_t            grant_q, grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic              err_q, err_d;
    logic [AW-1:0]     cpu_a_q, cpu_a_d;
    logic [DW-1:0]     cpu_wd_q, cpu_wd_d;
    logic [DW-1:0]     cpu_do_q, cpu_do_d;
    logic [DW-1:0]     vid_do_q, vid_do_d;
    logic [STAT_W-1:0] stalls_q, stalls_d;

    logic              ram_en, ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_rdata;

    logic              rd_latch, wr_latch, strobe_clash;

    assign rd_latch     = CP1_NEGEDGE && !CPU_NCS && !CPU_RDB &&  CPU_WRB;
    assign wr_latch     = CP2_NEGEDGE && !CPU_NCS &&  CPU_RDB && !CPU_WRB;
    assign strobe_clash = (CP1_NEGEDGE || CP2_NEGEDGE) && !CPU_NCS && !CPU_RDB && !CPU_WRB;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            grant_q   <= G_IDLE;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            err_q     <= 1'b0;
            cpu_a_q   <= '0;
            cpu_wd_q  <= '0;
            cpu_do_q  <= '0;
            vid_do_q  <= '0;
            stalls_q  <= '0;
        end else begin
            grant_q   <= grant_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            err_q     <= err_d;
            cpu_a_q   <= cpu_a_d;
            cpu_wd_q  <= cpu_wd_d;
            cpu_do_q  <= cpu_do_d;
            vid_do_q  <= vid_do_d;
            stalls_q  <= stalls_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_d   = G_IDLE;
        rd_pend_d = rd_pend_q;
        wr_pend_d = wr_pend_q;
        err_d     = err_q;
        cpu_a_d   = cpu_a_q;
        cpu_wd_d  = cpu_wd_q;
        cpu_do_d  = cpu_do_q;
        vid_do_d  = vid_do_q;
        stalls_d  = stalls_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cpu_a_q;

        // RESET also blocks the RAM strobes so a reset never lands a partial write.
        if (!RESET) begin
            if (rd_pend_q) begin
                grant_d   = G_CPU_RD;
                rd_pend_d = 1'b0;
                ram_en    = 1'b1;
            end else if (wr_pend_q) begin
                grant_d   = G_CPU_WR;
                wr_pend_d = 1'b0;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
            end else if (VID_REQ) begin
                grant_d   = G_VID;
                ram_en    = 1'b1;
                ram_addr  = VID_A;
            end
        end

        if (rd_latch) begin
            rd_pend_d = 1'b1;
            cpu_a_d   = CPU_A;
        end
        if (wr_latch) begin
            wr_pend_d = 1'b1;
            cpu_a_d   = CPU_A;
            cpu_wd_d  = CPU_DI;
        end
        if (strobe_clash) begin
            err_d = 1'b1;
        end

        // Read data arrives the CLK after the grant; capture it so the outputs hold afterwards.
        if (grant_q == G_CPU_RD) begin
            cpu_do_d = ram_rdata;
        end
        if (grant_q == G_VID) begin
            vid_do_d = ram_rdata;
        end

        if (VID_REQ && (grant_d != G_VID) && (stalls_q != '1)) begin
            stalls_d = stalls_q + 1'b1;
        end
    end

    scv_vram_sp #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i   (CLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (cpu_wd_q),
        .rdata_o (ram_rdata)
    );

    assign VID_ACK    = (grant_d == G_VID);
    assign VID_DV     = (grant_q == G_VID);
    assign VID_DO     = (grant_q == G_VID)    ? ram_rdata : vid_do_q;
    assign CPU_DO     = (grant_q == G_CPU_RD) ? ram_rdata : cpu_do_q;
    assign VID_STALLS = stalls_q;
    assign CPU_ERR    = err_q;

endmodule

// File: tb/tb_scv_vram_arb.sv
// Self-checking bench for scv_vram_arb: vector table, hand sequences and a randomized run against a slot-level model.
module tb_scv_vram_arb;
    import scv_pkg::*;

    localparam int AW = VRAM_AW;
    localparam int DW = 8;
    localparam int SW = 5;
    localparam logic [SW-1:0] SAT = '1;

    typedef enum int {K_IDLE, K_RD, K_WR, K_ERR, K_NCS} kind_e;

    typedef struct {
        kind_e         kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_do;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CP1_NEGEDGE = 1'b0;
    logic          CP2_NEGEDGE = 1'b0;
    logic          CPU_NCS = 1'b1;
    logic          CPU_RDB = 1'b1;
    logic          CPU_WRB = 1'b1;
    logic [AW-1:0] CPU_A = '0;
    logic [DW-1:0] CPU_DI = '0;
    logic [DW-1:0] CPU_DO;
    logic          VID_REQ = 1'b1;
    logic [AW-1:0] VID_A = '0;
    logic          VID_ACK;
    logic [DW-1:0] VID_DO;
    logic          VID_DV;
    logic [SW-1:0] VID_STALLS;
    logic          CPU_ERR;

    scv_vram_arb #(
        .AW     (AW),
        .DW     (DW),
        .STAT_W (SW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CP1_NEGEDGE (CP1_NEGEDGE),
        .CP2_NEGEDGE (CP2_NEGEDGE),
        .CPU_NCS     (CPU_NCS),
        .CPU_RDB     (CPU_RDB),
        .CPU_WRB     (CPU_WRB),
        .CPU_A       (CPU_A),
        .CPU_DI      (CPU_DI),
        .CPU_DO      (CPU_DO),
        .VID_REQ     (VID_REQ),
        .VID_A       (VID_A),
        .VID_ACK     (VID_ACK),
        .VID_DO      (VID_DO),
        .VID_DV      (VID_DV),
        .VID_STALLS  (VID_STALLS),
        .CPU_ERR     (CPU_ERR)
    );

    always #5 CLK = ~CLK;

    int            n_pass = 0;
    int            n_chk  = 0;
    int            phase  = 0;
    bit            vid_auto = 1'b0;
    logic          s_ack, s_dv;
    logic [DW-1:0] s_vdo, s_cdo;
    logic          ack_ph [4];
    logic [DW-1:0] cdo_ph [4];
    logic [DW-1:0] mref [0:(1<<AW)-1];
    vec_t          tbl [10];

    // random-run model state
    kind_e         rk;
    logic [AW-1:0] ra, a_now;
    logic [DW-1:0] rd, dv_data, exp_cdo;
    logic          exp_ack, req_now, dv_pend, prev_wr, err_model;
    logic [SW-1:0] st_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One CLK period: ticks follow the 4-phase pattern cp1p, cp1n, cp2p, cp2n.
    task automatic run_cycle();
        CP1_NEGEDGE = (phase == 1);
        CP2_NEGEDGE = (phase == 3);
        @(negedge CLK);
        s_ack = VID_ACK;
        s_dv  = VID_DV;
        s_vdo = VID_DO;
        s_cdo = CPU_DO;
        ack_ph[phase] = VID_ACK;
        cdo_ph[phase] = CPU_DO;
        @(posedge CLK);
        #1;
        if (vid_auto && s_ack) VID_A = VID_A + 1'b1;
        phase = (phase + 1) % 4;
    endtask

    task automatic drive_cpu(input kind_e k, input int p);
        CPU_NCS = (k == K_IDLE) || (k == K_NCS);
        case (k)
            K_RD, K_NCS: begin CPU_RDB = 1'b0; CPU_WRB = 1'b1; end
            K_WR:        begin CPU_RDB = 1'b1; CPU_WRB = 1'b0; end
            K_ERR:       begin CPU_RDB = (p < 2); CPU_WRB = 1'b0; end
            default:     begin CPU_RDB = 1'b1; CPU_WRB = 1'b1; end
        endcase
    endtask

    task automatic cpu_cycle(input kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        CPU_A  = a;
        CPU_DI = d;
        for (int p = 0; p < 4; p++) begin
            drive_cpu(k, p);
            run_cycle();
        end
        if (k == K_WR) mref[a] = d;
        drive_cpu(K_IDLE, 0);
    endtask

    task automatic align();
        while (phase != 0) run_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{K_WR,  10'h123, 8'h5A, 8'h00};
        tbl[1] = '{K_RD,  10'h123, 8'h00, 8'h5A};
        tbl[2] = '{K_WR,  10'h040, 8'h3C, 8'h5A};
        tbl[3] = '{K_RD,  10'h040, 8'h00, 8'h3C};
        tbl[4] = '{K_WR,  10'h3FF, 8'hC3, 8'h3C};
        tbl[5] = '{K_RD,  10'h3FF, 8'h00, 8'hC3};
        tbl[6] = '{K_WR,  10'h000, 8'h11, 8'hC3};
        tbl[7] = '{K_NCS, 10'h123, 8'h00, 8'hC3};
        tbl[8] = '{K_RD,  10'h123, 8'h00, 8'h5A};
        tbl[9] = '{K_RD,  10'h040, 8'h00, 8'h3C};

        // Reset state, with a video request present during reset.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_cpu_do",  CPU_DO, 0);
        check("rst_vid_ack", VID_ACK, 0);
        check("rst_vid_do",  VID_DO, 0);
        check("rst_vid_dv",  VID_DV, 0);
        check("rst_stalls",  VID_STALLS, 0);
        check("rst_cpu_err", CPU_ERR, 0);
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        VID_REQ = 1'b0;
        phase   = 0;

        // Table: CPU writes/reads, CPU_DO only changes on a read.
        for (int i = 0; i < 10; i++) begin
            cpu_cycle(tbl[i].kind, tbl[i].addr, tbl[i].wdata);
            check("tbl_cpu_do", cdo_ph[3], tbl[i].exp_do);
        end

        for (int i = 0; i < 16; i++) cpu_cycle(K_WR, AW'(i), DW'(8'h5C ^ (i * 8'h1D)));
        cpu_cycle(K_IDLE, '0, '0);

        // Video streaming 000..00F with no CPU traffic.
        VID_A    = '0;
        VID_REQ  = 1'b1;
        vid_auto = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) VID_REQ = 1'b0;
            run_cycle();
            check("t2_ack", s_ack, (i < 16));
            if (i > 0) begin
                check("t2_dv", s_dv, 1);
                check("t2_vdo", s_vdo, mref[i-1]);
            end
        end
        vid_auto = 1'b0;
        align();
        check("t2_stalls", VID_STALLS, 0);

        // Video held across 4 CPU reads: ACK missing only in each read slot.
        VID_A    = '0;
        VID_REQ  = 1'b1;
        vid_auto = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cpu_cycle(K_RD, AW'(r + 4), '0);
            for (int p = 0; p < 4; p++) check("t3_ack", ack_ph[p], (p != 2));
            check("t3_cpu_do", cdo_ph[3], mref[r+4]);
        end
        VID_REQ  = 1'b0;
        vid_auto = 1'b0;
        check("t3_stalls", VID_STALLS, 4);

        // CPU write then video read of the same word in the next free CLK.
        cpu_cycle(K_WR, 10'h040, 8'hA5);
        VID_REQ = 1'b1;
        VID_A   = 10'h040;
        run_cycle();
        check("t4_ack_wrslot", s_ack, 0);
        run_cycle();
        check("t4_ack", s_ack, 1);
        VID_REQ = 1'b0;
        run_cycle();
        check("t4_dv", s_dv, 1);
        check("t4_vdo", s_vdo, 8'hA5);
        align();
        check("t4_stalls", VID_STALLS, 5);

        // Both strobes low at the cp2n tick: no write, sticky error.
        cpu_cycle(K_ERR, 10'h123, 8'hFF);
        check("t5_err", CPU_ERR, 1);
        cpu_cycle(K_RD, 10'h123, '0);
        check("t5_rd_unchanged", cdo_ph[3], 8'h5A);
        check("t5_err_sticky", CPU_ERR, 1);

        // Randomized run against a slot-level model.
        st_model  = 5;
        exp_cdo   = 8'h5A;
        err_model = 1'b1;
        prev_wr   = 1'b0;
        dv_pend   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rk = kind_e'($urandom_range(0, 4));
            ra = AW'($urandom_range(0, 15));
            rd = DW'($urandom);
            CPU_A  = ra;
            CPU_DI = rd;
            for (int p = 0; p < 4; p++) begin
                drive_cpu(rk, p);
                if (!VID_REQ && ($urandom_range(0, 9) < 7)) begin
                    VID_REQ = 1'b1;
                    VID_A   = AW'($urandom_range(0, 15));
                end
                // CPU owns the cp2p CLK after a read latch and the cp1p CLK after a write latch.
                exp_ack = VID_REQ && !((p == 2 && rk == K_RD) || (p == 0 && prev_wr));
                req_now = VID_REQ;
                a_now   = VID_A;
                run_cycle();
                check("rnd_ack", s_ack, exp_ack);
                check("rnd_dv", s_dv, dv_pend);
                if (dv_pend) check("rnd_vdo", s_vdo, dv_data);
                dv_pend = exp_ack;
                if (exp_ack) dv_data = mref[a_now];
                if (req_now && !exp_ack && st_model != SAT) st_model = st_model + 1'b1;
                check("rnd_stalls", VID_STALLS, st_model);
                if (p == 1 && rk == K_RD) exp_cdo = mref[ra];
                if (p == 3) begin
                    check("rnd_cpu_do", s_cdo, exp_cdo);
                    if (rk == K_WR) mref[ra] = rd;
                    if (rk == K_ERR) err_model = 1'b1;
                    check("rnd_err", CPU_ERR, err_model);
                end
                if (s_ack) begin
                    if ($urandom_range(0, 1) == 1) VID_A = AW'($urandom_range(0, 15));
                    else VID_REQ = 1'b0;
                end
            end
            prev_wr = (rk == K_WR);
        end
        drive_cpu(K_IDLE, 0);

        // Saturation: 32 read slots with video held.
        VID_REQ  = 1'b1;
        VID_A    = '0;
        vid_auto = 1'b1;
        for (int r = 0; r < 32; r++) cpu_cycle(K_RD, 10'h000, '0);
        check("sat_stalls", VID_STALLS, SAT);
        check("sat_cpu_do", CPU_DO, mref[0]);

        // Reset the CLK after an ACK: in-flight DV suppressed, RAM keeps its contents.
        run_cycle();
        check("t6_ack", s_ack, 1);
        RESET    = 1'b1;
        VID_REQ  = 1'b0;
        vid_auto = 1'b0;
        CP1_NEGEDGE = 1'b0;
        CP2_NEGEDGE = 1'b0;
        #1;
        check("t6_dv", VID_DV, 0);
        check("t6_stalls", VID_STALLS, 0);
        check("t6_err", CPU_ERR, 0);
        check("t6_cpu_do", CPU_DO, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        phase = 0;
        cpu_cycle(K_RD, 10'h123, '0);
        check("t6_keep_123", cdo_ph[3], 8'h5A);
        cpu_cycle(K_RD, 10'h3FF, '0);
        check("t6_keep_3ff", cdo_ph[3], 8'hC3);
        check("t6_err_clear", CPU_ERR, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
